// File: rtl/frame_pair_pkg.sv
// frame_pair_pkg: shared state encodings, default width and packed-beat field offsets for the pair stream
package frame_pair_pkg;
  localparam int TDATA_WIDTH_DEF = 24;
  localparam int CUR_LSB = 0;
  localparam int PREV_LSB = TDATA_WIDTH_DEF;
  typedef enum logic {SEEK, STREAM} state_t;
endpackage

// File: rtl/frame_pair_packer_skid.sv
// axis_skid_reg: 2-entry registered skid buffer; s_ready depends only on occupancy
// Ports: clk, rst (sync, active-high); s_data/s_valid/s_ready upstream; m_data/m_valid/m_ready downstream.
module axis_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);
  logic [W-1:0] skid_data;
  logic         skid_valid;
  logic         push, pop;
  assign s_ready = ~skid_valid;
  assign push = s_valid & s_ready;
  assign pop = m_valid & m_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!m_valid || pop) begin
      m_valid <= skid_valid | push;
      if (skid_valid) m_data <= skid_data;
      else if (push) m_data <= s_data;
      skid_valid <= 1'b0;
    end else if (push) begin
      skid_data <= s_data;
      skid_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/frame_pair_packer.sv
// frame_pair_packer: joins current and previous-frame AXIS video into one SOF-aligned pair stream
// Ports: aclk, areset (sync, active-high); s_cur_* and s_prev_* AXIS inputs; m_pair_* joined output
//   (tdata = {prev, cur}); sync_ok high while streaming.
// Optional FRAME_PAIR_STATS_EN adds resync_count (saturating) and frames_paired (wrapping).
module frame_pair_packer
  import frame_pair_pkg::*;
#(
  parameter int TDATA_WIDTH = TDATA_WIDTH_DEF
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [TDATA_WIDTH-1:0]   s_cur_tdata,
  input  logic                     s_cur_tuser,
  input  logic                     s_cur_tlast,
  input  logic                     s_cur_tvalid,
  output logic                     s_cur_tready,
  input  logic [TDATA_WIDTH-1:0]   s_prev_tdata,
  input  logic                     s_prev_tuser,
  input  logic                     s_prev_tlast,
  input  logic                     s_prev_tvalid,
  output logic                     s_prev_tready,
  output logic [2*TDATA_WIDTH-1:0] m_pair_tdata,
  output logic                     m_pair_tuser,
  output logic                     m_pair_tlast,
  output logic                     m_pair_tvalid,
  input  logic                     m_pair_tready,
`ifdef FRAME_PAIR_STATS_EN
  output logic [15:0]              resync_count,
  output logic [15:0]              frames_paired,
`endif
  output logic                     sync_ok
);
  localparam int PW = 2*TDATA_WIDTH + 2;
  state_t          state, state_nx;
  logic            both_v, desync, join_hs, skid_ready, out_valid;
  logic [PW-1:0]   beat, out_beat;
  always_ff @(posedge aclk) state <= areset ? SEEK : state_nx;
  always_comb begin
    both_v = s_cur_tvalid & s_prev_tvalid;
    desync = both_v & ((s_cur_tuser ^ s_prev_tuser) | (s_cur_tlast ^ s_prev_tlast));
    join_hs = ~areset & (state == STREAM) & both_v & ~desync & skid_ready;
    state_nx = (state == SEEK) ? ((both_v & s_cur_tuser & s_prev_tuser) ? STREAM : SEEK)
                               : (desync ? SEEK : STREAM);
    // In SEEK non-SOF beats are dropped and SOF beats wait for the other side
    s_cur_tready = ~areset & ((state == SEEK) ? (s_cur_tvalid & ~s_cur_tuser) : join_hs);
    s_prev_tready = ~areset & ((state == SEEK) ? (s_prev_tvalid & ~s_prev_tuser) : join_hs);
    beat = '0;
    beat[CUR_LSB +: TDATA_WIDTH] = s_cur_tdata;
    beat[CUR_LSB + TDATA_WIDTH +: TDATA_WIDTH] = s_prev_tdata;
    beat[PW-2] = s_cur_tuser;
    beat[PW-1] = s_cur_tlast;
  end
  axis_skid_reg #(.W(PW)) u_skid (
    .clk(aclk),
    .rst(areset),
    .s_data(beat),
    .s_valid(join_hs),
    .s_ready(skid_ready),
    .m_data(out_beat),
    .m_valid(out_valid),
    .m_ready(m_pair_tready)
  );
  assign m_pair_tdata = out_beat[2*TDATA_WIDTH-1:0];
  assign m_pair_tuser = out_beat[PW-2];
  assign m_pair_tlast = out_beat[PW-1];
  assign m_pair_tvalid = out_valid & ~areset;
  assign sync_ok = ~areset & (state == STREAM);
`ifdef FRAME_PAIR_STATS_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      resync_count <= '0;
      frames_paired <= '0;
    end else begin
      if (state == STREAM && desync && resync_count != 16'hFFFF) resync_count <= resync_count + 16'd1;
      if (m_pair_tvalid && m_pair_tready && m_pair_tuser) frames_paired <= frames_paired + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_frame_pair_packer.sv
// tb_frame_pair_packer: directed table and sequence checks of the pair packer
module tb_frame_pair_packer;
  localparam int TW = 24;
  logic            aclk = 1'b0;
  logic            areset = 1'b1;
  logic [TW-1:0]   s_cur_tdata = '0, s_prev_tdata = '0;
  logic            s_cur_tuser = 1'b0, s_cur_tlast = 1'b0, s_cur_tvalid = 1'b0, s_cur_tready;
  logic            s_prev_tuser = 1'b0, s_prev_tlast = 1'b0, s_prev_tvalid = 1'b0, s_prev_tready;
  logic [2*TW-1:0] m_pair_tdata;
  logic            m_pair_tuser, m_pair_tlast, m_pair_tvalid, m_pair_tready = 1'b0, sync_ok;
`ifdef FRAME_PAIR_STATS_EN
  logic [15:0]     resync_count, frames_paired;
`endif
  always #5 aclk = ~aclk;
  frame_pair_packer #(.TDATA_WIDTH(TW)) dut (
    .aclk(aclk), .areset(areset),
    .s_cur_tdata(s_cur_tdata), .s_cur_tuser(s_cur_tuser), .s_cur_tlast(s_cur_tlast),
    .s_cur_tvalid(s_cur_tvalid), .s_cur_tready(s_cur_tready),
    .s_prev_tdata(s_prev_tdata), .s_prev_tuser(s_prev_tuser), .s_prev_tlast(s_prev_tlast),
    .s_prev_tvalid(s_prev_tvalid), .s_prev_tready(s_prev_tready),
    .m_pair_tdata(m_pair_tdata), .m_pair_tuser(m_pair_tuser), .m_pair_tlast(m_pair_tlast),
    .m_pair_tvalid(m_pair_tvalid), .m_pair_tready(m_pair_tready),
`ifdef FRAME_PAIR_STATS_EN
    .resync_count(resync_count), .frames_paired(frames_paired),
`endif
    .sync_ok(sync_ok)
  );
  typedef logic [TW+1:0] beat_t;
  typedef logic [2*TW+1:0] pair_t;
  typedef struct {
    logic cv, cu, pv, pu;
    logic exp_cr, exp_pr, exp_sync;
  } seek_vec_t;
  beat_t cur_q[$], prev_q[$];
  pair_t exp_q[$], got_q[$];
  int checks = 0, failures = 0, cyc = 0;
  int first_hs, first_out, last_out, cur_drop, prev_drop, stab_err, rdy_err;
  bit sync_fell, was_sync;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push_beat(input bit which, input int d, input bit u, input bit l);
    if (which) prev_q.push_back({l, u, TW'(d)});
    else cur_q.push_back({l, u, TW'(d)});
  endtask
  task automatic add_pair_frame(input int w, input int h, input int cb, input int pb, input bit ex);
    bit u, l;
    for (int i = 0; i < w*h; i++) begin
      u = (i == 0);
      l = (i % w == w - 1);
      push_beat(0, cb + i, u, l);
      push_beat(1, pb + i, u, l);
      if (ex) exp_q.push_back({l, u, TW'(pb + i), TW'(cb + i)});
    end
  endtask
  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    s_cur_tvalid = 1'b0;
    s_prev_tvalid = 1'b0;
    m_pair_tready = 1'b0;
    cur_q.delete(); prev_q.delete(); exp_q.delete(); got_q.delete();
    first_hs = -1; first_out = -1; last_out = -1;
    cur_drop = 0; prev_drop = 0; stab_err = 0; rdy_err = 0;
    sync_fell = 0; was_sync = 0;
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
  endtask
  // mode: 0 ready low, 1 ready high, 2 random ready
  task automatic run(input int n, input int gap, input int mode);
    bit cur_hs = 0, prev_hs = 0, stall = 0;
    pair_t last_seen = '0, now;
    for (int k = 0; k < n; k++) begin
      @(negedge aclk);
      if (cur_hs) s_cur_tvalid = 1'b0;
      if (prev_hs) s_prev_tvalid = 1'b0;
      if (!s_cur_tvalid && cur_q.size() > 0 && cyc % gap == 0) s_cur_tvalid = 1'b1;
      if (!s_prev_tvalid && prev_q.size() > 0) s_prev_tvalid = 1'b1;
      if (s_cur_tvalid) {s_cur_tlast, s_cur_tuser, s_cur_tdata} = cur_q[0];
      if (s_prev_tvalid) {s_prev_tlast, s_prev_tuser, s_prev_tdata} = prev_q[0];
      m_pair_tready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
      #1;
      now = {m_pair_tlast, m_pair_tuser, m_pair_tdata};
      if (m_pair_tvalid && stall && now !== last_seen) stab_err++;
      stall = m_pair_tvalid && !m_pair_tready;
      last_seen = now;
      if (sync_ok && (s_cur_tready != s_prev_tready)) rdy_err++;
      if (m_pair_tvalid && m_pair_tready) begin
        got_q.push_back(now);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      cur_hs = s_cur_tvalid && s_cur_tready;
      prev_hs = s_prev_tvalid && s_prev_tready;
      if (cur_hs && prev_hs && sync_ok && first_hs < 0) first_hs = cyc;
      if (cur_hs) begin
        if (!sync_ok) cur_drop++;
        void'(cur_q.pop_front());
      end
      if (prev_hs) begin
        if (!sync_ok) prev_drop++;
        void'(prev_q.pop_front());
      end
      if (sync_ok) was_sync = 1;
      else if (was_sync) sync_fell = 1;
      cyc++;
    end
  endtask
  task automatic compare(input string tag);
    chk($sformatf("%s_count", tag), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask
  seek_vec_t vt[4];
  initial begin
    vt[0] = '{cv:1, cu:0, pv:1, pu:0, exp_cr:1, exp_pr:1, exp_sync:0};
    vt[1] = '{cv:1, cu:1, pv:1, pu:0, exp_cr:0, exp_pr:1, exp_sync:0};
    vt[2] = '{cv:1, cu:0, pv:1, pu:1, exp_cr:1, exp_pr:0, exp_sync:0};
    vt[3] = '{cv:1, cu:1, pv:1, pu:1, exp_cr:0, exp_pr:0, exp_sync:1};
    s_cur_tvalid = 1'b1;
    s_prev_tvalid = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_cur_ready", 64'(s_cur_tready), 64'd0);
    chk("rst_prev_ready", 64'(s_prev_tready), 64'd0);
    chk("rst_m_valid", 64'(m_pair_tvalid), 64'd0);
    chk("rst_sync_ok", 64'(sync_ok), 64'd0);
    @(negedge aclk);
    areset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      s_cur_tvalid = vt[i].cv; s_cur_tuser = vt[i].cu; s_cur_tdata = TW'(i);
      s_prev_tvalid = vt[i].pv; s_prev_tuser = vt[i].pu; s_prev_tdata = TW'(i);
      #1;
      chk($sformatf("seek%0d_cur_ready", i), 64'(s_cur_tready), 64'(vt[i].exp_cr));
      chk($sformatf("seek%0d_prev_ready", i), 64'(s_prev_tready), 64'(vt[i].exp_pr));
      chk($sformatf("seek%0d_m_valid", i), 64'(m_pair_tvalid), 64'd0);
      @(posedge aclk);
      #1;
      chk($sformatf("seek%0d_sync", i), 64'(sync_ok), 64'(vt[i].exp_sync));
    end
    // 1: prev reaches SOF 7 beats after cur
    do_reset();
    for (int i = 0; i < 2; i++) push_beat(0, 'hEEE000 + i, 0, 0);
    for (int i = 0; i < 9; i++) push_beat(1, 'hDDD000 + i, 0, 0);
    add_pair_frame(2, 2, 'h010203, 'h0A0B0C, 1);
    run(30, 1, 1);
    chk("t1_cur_drop", 64'(cur_drop), 64'd2);
    chk("t1_prev_drop", 64'(prev_drop), 64'd9);
    chk("t1_first", 64'(got_q.size() > 0 ? got_q[0] : '0), {14'd0, 1'b0, 1'b1, 24'h0A0B0C, 24'h010203});
    compare("t1");
    // 2: aligned 4x2 frame, full throughput
    do_reset();
    add_pair_frame(4, 2, 'hD00, 'hE00, 1);
    run(20, 1, 1);
    compare("t2");
    chk("t2_latency", 64'(first_out - first_hs), 64'd1);
    chk("t2_back2back", 64'(last_out - first_out), 64'd7);
    chk("t2_tlast4", 64'(got_q.size() > 3 ? got_q[3][2*TW+1] : 1'b0), 64'd1);
    chk("t2_tlast8", 64'(got_q.size() > 7 ? got_q[7][2*TW+1] : 1'b0), 64'd1);
    // 3: random backpressure on a 16x4 frame
    do_reset();
    add_pair_frame(16, 4, 'hB000, 'hC000, 1);
    run(400, 1, 2);
    compare("t3");
    chk("t3_stable", 64'(stab_err), 64'd0);
    // 4: tlast desync then relock on the next common SOF
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push_beat(0, 'h100 + i, i == 0, i == 2 || i == 5);
      push_beat(1, 'h200 + i, i == 0, i == 3 || i == 5);
    end
    for (int i = 0; i < 2; i++) exp_q.push_back({1'b0, i == 0, TW'('h200 + i), TW'('h100 + i)});
    add_pair_frame(2, 2, 'h300, 'h400, 1);
    run(40, 1, 1);
    compare("t4");
    chk("t4_sync_fell", 64'(sync_fell), 64'd1);
    chk("t4_relock", 64'(sync_ok), 64'd1);
`ifdef FRAME_PAIR_STATS_EN
    chk("t4_resync_count", 64'(resync_count), 64'd1);
    chk("t4_frames_paired", 64'(frames_paired), 64'd2);
`endif
    // 5: reset while the skid buffer is full
    do_reset();
    add_pair_frame(4, 2, 'h500, 'h600, 0);
    run(6, 1, 0);
    chk("t5_full_valid", 64'(m_pair_tvalid), 64'd1);
    chk("t5_full_ready", 64'(s_cur_tready), 64'd0);
    @(negedge aclk);
    areset = 1'b1;
    #1;
    chk("t5_rst_cur_ready", 64'(s_cur_tready), 64'd0);
    chk("t5_rst_prev_ready", 64'(s_prev_tready), 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    chk("t5_after_valid", 64'(m_pair_tvalid), 64'd0);
    chk("t5_after_sync", 64'(sync_ok), 64'd0);
    add_pair_frame(2, 2, 'h700, 'h800, 1);
    run(30, 1, 1);
    compare("t5");
    // 6: gapped current stream
    do_reset();
    add_pair_frame(4, 2, 'h900, 'hA00, 1);
    run(60, 3, 1);
    compare("t6");
    chk("t6_ready_pair", 64'(rdy_err), 64'd0);
    chk("t6_rate", 64'(last_out - first_out >= 18), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
